skin_chroma_xform: RTL and testbench



---
 rtl/skin_chroma_xform_pkg.sv | 35 +++
 rtl/chroma_lut_ram.sv | 31 +++
 rtl/skin_chroma_xform.sv | 155 +++++++++++++++
 tb/tb_skin_chroma_xform.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_chroma_xform_pkg.sv
// Shared definitions for the skin-tone chroma transform.
//   - Default parameter values for the transform datapath.
//   - Chroma table select encodings (lut_chan).
//   - Unsigned saturation helper used on the output stage.
package skin_chroma_xform_pkg;

  localparam int DEF_FP_WIDTH  = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_K_L       = 125;
  localparam int DEF_K_H       = 188;
  localparam int DEF_CB_CENTER = 108;
  localparam int DEF_CR_CENTER = 154;

  localparam int LUT_DEPTH = 256;

  typedef enum logic {
    CHAN_CB = 1'b0,
    CHAN_CR = 1'b1
  } chroma_chan_e;

  // Clamp a signed value into [0, 2^w - 1]; caller truncates to w bits.
  function automatic logic [31:0] sat_unsigned(input logic signed [31:0] v,
                                               input int unsigned w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v < 0)
      return '0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/chroma_lut_ram.sv
// 256-entry single-write / single-read synchronous RAM holding one chroma
// table ({mean, scale} per luma index).
//   clk   : clock
//   we    : write strobe, waddr/wdata written on the clock edge
//   re    : read enable, rdata loads mem[raddr] on the clock edge
//   rdata : registered read data; a same-edge write to raddr returns old data
// Contents are not reset.
module chroma_lut_ram
  import skin_chroma_xform_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/skin_chroma_xform.sv
// Nonlinear Cb/Cr transform with luma-indexed, host-loaded mean/scale tables.
// Four-stage valid/ready pipeline, 1 pixel/clk, all stages stall together.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_y/in_cb/in_cr pixel
//   out_valid/out_ready  : output handshake, out_y/out_cb/out_cr result
//   lut_we/lut_chan/lut_addr/lut_mean/lut_scale : table write port
// Optional build macro SKIN_XFORM_STATS_EN adds count_clr (in) and
// xform_count (out, 32): count of output pixels that were transformed.
module skin_chroma_xform
  import skin_chroma_xform_pkg::*;
#(
  parameter int FP_WIDTH  = DEF_FP_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int K_L       = DEF_K_L,
  parameter int K_H       = DEF_K_H,
  parameter int CB_CENTER = DEF_CB_CENTER,
  parameter int CR_CENTER = DEF_CR_CENTER
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_y,
  input  logic [7:0]           in_cb,
  input  logic [7:0]           in_cr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_y,
  output logic [OUT_WIDTH-1:0] out_cb,
  output logic [OUT_WIDTH-1:0] out_cr,
`ifdef SKIN_XFORM_STATS_EN
  input  logic                 count_clr,
  output logic [31:0]          xform_count,
`endif
  input  logic                 lut_we,
  input  logic                 lut_chan,
  input  logic [7:0]           lut_addr,
  input  logic [7:0]           lut_mean,
  input  logic [FP_WIDTH-1:0]  lut_scale
);

  localparam int LUT_W  = 8 + FP_WIDTH;
  localparam int PROD_W = 9 + FP_WIDTH;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Tables: read is enabled only on advance so a stalled S1 keeps its entry
  // even if the host rewrites that address meanwhile.
  logic             cb_we, cr_we;
  logic [LUT_W-1:0] lut_wdata, cb_rd, cr_rd;

  assign cb_we     = lut_we & (lut_chan == CHAN_CB);
  assign cr_we     = lut_we & (lut_chan == CHAN_CR);
  assign lut_wdata = {lut_mean, lut_scale};

  chroma_lut_ram #(.DATA_W(LUT_W)) u_cb_lut (
    .clk(clk), .we(cb_we), .waddr(lut_addr), .wdata(lut_wdata),
    .re(advance), .raddr(in_y), .rdata(cb_rd)
  );

  chroma_lut_ram #(.DATA_W(LUT_W)) u_cr_lut (
    .clk(clk), .we(cr_we), .waddr(lut_addr), .wdata(lut_wdata),
    .re(advance), .raddr(in_y), .rdata(cr_rd)
  );

  // S1
  logic       v1, band1;
  logic [7:0] y1, cb1, cr1;
  // S2
  logic                       v2, band2;
  logic [7:0]                 y2, cb2, cr2;
  logic signed [8:0]          d2cb, d2cr;
  logic signed [FP_WIDTH-1:0] s2cb, s2cr;
  // S3
  logic                     v3, band3;
  logic [7:0]               y3, cb3, cr3;
  logic signed [PROD_W-1:0] p3cb, p3cr;
  // S4 combinational result
  logic signed [PROD_W-1:0] sh_cb, sh_cr;
  logic [31:0]              sum_cb, sum_cr;
  logic [OUT_WIDTH-1:0]     nx_cb, nx_cr;

  always_comb begin
    sh_cb  = p3cb >>> FRAC_BITS;
    sh_cr  = p3cr >>> FRAC_BITS;
    sum_cb = 32'(sh_cb) + 32'(CB_CENTER);
    sum_cr = 32'(sh_cr) + 32'(CR_CENTER);
    nx_cb  = band3 ? OUT_WIDTH'(cb3) : OUT_WIDTH'(sat_unsigned(sum_cb, OUT_WIDTH));
    nx_cr  = band3 ? OUT_WIDTH'(cr3) : OUT_WIDTH'(sat_unsigned(sum_cr, OUT_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; band1 <= 1'b0; y1 <= '0; cb1 <= '0; cr1 <= '0;
      v2 <= 1'b0; band2 <= 1'b0; y2 <= '0; cb2 <= '0; cr2 <= '0;
      d2cb <= '0; d2cr <= '0; s2cb <= '0; s2cr <= '0;
      v3 <= 1'b0; band3 <= 1'b0; y3 <= '0; cb3 <= '0; cr3 <= '0;
      p3cb <= '0; p3cr <= '0;
      out_valid <= 1'b0; out_y <= '0; out_cb <= '0; out_cr <= '0;
    end else if (advance) begin
      v1    <= in_valid;
      y1    <= in_y;
      cb1   <= in_cb;
      cr1   <= in_cr;
      band1 <= (int'(in_y) >= K_L) && (int'(in_y) <= K_H);

      v2    <= v1;
      y2    <= y1;
      cb2   <= cb1;
      cr2   <= cr1;
      band2 <= band1;
      d2cb  <= {1'b0, cb1} - {1'b0, cb_rd[LUT_W-1 -: 8]};
      d2cr  <= {1'b0, cr1} - {1'b0, cr_rd[LUT_W-1 -: 8]};
      s2cb  <= cb_rd[FP_WIDTH-1:0];
      s2cr  <= cr_rd[FP_WIDTH-1:0];

      v3    <= v2;
      y3    <= y2;
      cb3   <= cb2;
      cr3   <= cr2;
      band3 <= band2;
      p3cb  <= PROD_W'(d2cb) * PROD_W'(s2cb);
      p3cr  <= PROD_W'(d2cr) * PROD_W'(s2cr);

      out_valid <= v3;
      out_y     <= y3;
      out_cb    <= nx_cb;
      out_cr    <= nx_cr;
    end
  end

`ifdef SKIN_XFORM_STATS_EN
  logic band4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      band4 <= 1'b0;
    else if (advance)
      band4 <= band3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xform_count <= '0;
    else if (count_clr)
      xform_count <= '0;
    else if (out_valid & out_ready & ~band4)
      xform_count <= xform_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_skin_chroma_xform.sv
module tb_skin_chroma_xform;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_y = '0, in_cb = '0, in_cr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y, out_cb, out_cr;
  logic        lut_we = 1'b0;
  logic        lut_chan = 1'b0;
  logic [7:0]  lut_addr = '0, lut_mean = '0;
  logic [15:0] lut_scale = '0;
`ifdef SKIN_XFORM_STATS_EN
  logic        count_clr = 1'b0;
  logic [31:0] xform_count;
`endif

  always #5 clk = ~clk;

  skin_chroma_xform dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
`ifdef SKIN_XFORM_STATS_EN
    .count_clr(count_clr), .xform_count(xform_count),
`endif
    .lut_we(lut_we), .lut_chan(lut_chan), .lut_addr(lut_addr),
    .lut_mean(lut_mean), .lut_scale(lut_scale)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] y, cb, cr;
    bit         band;
  } pix_t;

  pix_t        q[$];
  logic [7:0]  m_mean[2][256];
  logic [15:0] m_sc[2][256];
  bit          prev_hold = 0;
  logic [7:0]  py, pcb, pcr;
  int unsigned cnt_m = 0;

  function automatic bit in_band(input int y);
    return (y >= 125) && (y <= 188);
  endfunction

  // Reference transform: plain integer arithmetic, floor shift, clamp.
  function automatic logic [7:0] xf(input int y, input int c, input int mean,
                                    input logic [15:0] sc, input int center);
    int d, p, s;
    if (in_band(y)) return 8'(c);
    d = c - mean;
    p = d * int'($signed(sc));
    s = (p >>> 8) + center;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / per-cycle compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_hold = 0;
      cnt_m = 0;
    end else begin
      pix_t e;
      bit   hs_band;
      hs_band = 1;
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
      if (prev_hold)
        check("hold", {7'd0, out_valid, out_y, out_cb, out_cr}, {7'd0, 1'b1, py, pcb, pcr});
`ifdef SKIN_XFORM_STATS_EN
      check("xform_count", xform_count, cnt_m);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got y=%0d with nothing expected at %0t", out_y, $time);
        end else begin
          e = q.pop_front();
          check("out_y", {24'd0, out_y}, {24'd0, e.y});
          check("out_cb", {24'd0, out_cb}, {24'd0, e.cb});
          check("out_cr", {24'd0, out_cr}, {24'd0, e.cr});
          hs_band = e.band;
        end
      end
`ifdef SKIN_XFORM_STATS_EN
      if (count_clr) cnt_m = 0;
      else if (out_valid && out_ready && !hs_band) cnt_m++;
`endif
      if (in_valid && in_ready) begin
        e.y    = in_y;
        e.band = in_band(in_y);
        e.cb   = xf(in_y, in_cb, m_mean[0][in_y], m_sc[0][in_y], 108);
        e.cr   = xf(in_y, in_cr, m_mean[1][in_y], m_sc[1][in_y], 154);
        q.push_back(e);
      end
      if (lut_we) begin
        m_mean[lut_chan][lut_addr] = lut_mean;
        m_sc[lut_chan][lut_addr]   = lut_scale;
      end
      prev_hold = out_valid && !out_ready;
      py = out_y; pcb = out_cb; pcr = out_cr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic write_lut(input logic c, input logic [7:0] a, input logic [7:0] m,
                           input logic [15:0] s);
    bit acc;
    lut_we = 1; lut_chan = c; lut_addr = a; lut_mean = m; lut_scale = s;
    cycle(acc);
    lut_we = 0;
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1; in_valid = 0;
    for (int i = 0; i < 30 && (q.size() != 0 || out_valid); i++) cycle(acc);
    check("drain", q.size() + int'(out_valid), 0);
  endtask

  task automatic direct(input string nm, input logic [7:0] y, cb, cr, ey, ecb, ecr,
                        input bit wr = 0, input logic wc = 0, input logic [7:0] wa = 0,
                        input logic [7:0] wm = 0, input logic [15:0] ws = 0);
    bit acc;
    int lat;
    drain();
    in_valid = 1; in_y = y; in_cb = cb; in_cr = cr;
    if (wr) begin
      lut_we = 1; lut_chan = wc; lut_addr = wa; lut_mean = wm; lut_scale = ws;
    end
    cycle(acc);
    in_valid = 0; lut_we = 0;
    check({nm, "_acc"}, {31'd0, acc}, 32'd1);
    lat = 1;
    while (!out_valid && lat < 12) begin cycle(acc); lat++; end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_y"}, {24'd0, out_y}, {24'd0, ey});
    check({nm, "_cb"}, {24'd0, out_cb}, {24'd0, ecb});
    check({nm, "_cr"}, {24'd0, out_cr}, {24'd0, ecr});
    cycle(acc);
  endtask

  initial begin
    bit acc;
    int idx, cyc, s;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 256; a++) begin m_mean[c][a] = '0; m_sc[c][a] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outs", {8'd0, out_y, out_cb, out_cr}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Random table contents
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 256; a++) begin
        s = int'($urandom_range(0, 1024)) - 512;
        write_lut(c[0], a[7:0], 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(s));
      end

    // Directed, literal expectations
    write_lut(1, 50, 150, 16'h0200);
    write_lut(0, 50, 120, 16'h0100);
    direct("nominal", 50, 130, 160, 50, 118, 174);
    write_lut(0, 124, 77, 16'h0100); write_lut(1, 124, 200, 16'h0100);
    write_lut(0, 189, 77, 16'h0100); write_lut(1, 189, 200, 16'h0100);
    direct("band125", 125, 77, 200, 125, 77, 200);
    direct("band188", 188, 77, 200, 188, 77, 200);
    direct("band124", 124, 77, 200, 124, 108, 154);
    direct("band189", 189, 77, 200, 189, 108, 154);
    write_lut(1, 60, 100, 16'h0400); write_lut(0, 60, 0, 16'h0100);
    direct("sat_hi", 60, 20, 250, 60, 128, 255);
    write_lut(1, 60, 150, 16'h0200);
    direct("sat_lo", 60, 20, 10, 60, 128, 0);
    write_lut(0, 70, 101, 16'h0080); write_lut(1, 70, 0, 16'h0000);
    direct("floor", 70, 100, 33, 70, 107, 154);
    write_lut(0, 80, 0, 16'h0100); write_lut(1, 80, 0, 16'h0000);
    direct("wr_same_cycle", 80, 10, 0, 80, 118, 154, 1, 0, 80, 10, 16'h0100);
    direct("wr_after", 80, 10, 0, 80, 108, 154);

    // Backpressure: 10 back-to-back pixels, out_ready low for 3 cycles
    drain();
    idx = 0; cyc = 0;
    in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
    while (idx < 10 && cyc < 60) begin
      in_valid = 1;
      out_ready = !(cyc >= 4 && cyc < 7);
      cycle(acc);
      if (cyc >= 4 && cyc < 7) check("bp_stall_acc", {31'd0, acc}, 32'd0);
      if (acc) begin
        idx++;
        in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
      end
      cyc++;
    end
    check("bp_sent", idx, 10);
    drain();

    // Reset with pixels in flight
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 12 && !out_valid; i++) begin
      in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
      cycle(acc);
    end
    rst_n = 0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outs", {8'd0, out_y, out_cb, out_cr}, 32'd0);
    in_valid = 0;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(acc);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    direct("post_rst", 50, 130, 160, 50, 118, 174);

`ifdef SKIN_XFORM_STATS_EN
    begin
      logic [7:0] ys [6];
      ys = '{8'd10, 8'd130, 8'd200, 8'd150, 8'd30, 8'd240};
      drain();
      count_clr = 1; cycle(acc); count_clr = 0;
      idx = 0;
      for (int i = 0; i < 30 && idx < 6; i++) begin
        in_valid = 1; in_y = ys[idx]; in_cb = 8'($urandom); in_cr = 8'($urandom);
        cycle(acc);
        if (acc) idx++;
      end
      in_valid = 0;
      drain();
      check("stats_count", xform_count, 32'd4);
      in_valid = 1; in_y = 10; in_cb = 40; in_cr = 40;
      cycle(acc);
      in_valid = 0;
      for (int i = 0; i < 12 && !out_valid; i++) cycle(acc);
      count_clr = 1; cycle(acc); count_clr = 0;
      check("stats_clr", xform_count, 32'd0);
    end
`endif

    // Random streaming with concurrent table writes
    drain();
    in_valid = 0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      lut_we = ($urandom_range(0, 11) == 0);
      lut_chan = 1'($urandom); lut_addr = 8'($urandom); lut_mean = 8'($urandom);
      s = int'($urandom_range(0, 1024)) - 512;
      lut_scale = 16'(s);
      cycle(acc);
    end
    lut_we = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
